// File: rtl/alu_ctrl_pipe_if.sv
// Decode-request / registered-op bus between main control and the ALU control pipe.
// The master side drives requests and pipeline controls. The slave side returns the registered op.
interface alu_ctrl_pipe_if #(
    parameter int OPC_W = 11,
    parameter int OP_W  = 4
);
    logic             in_valid;
    logic             in_ready;
    logic             stall;
    logic             flush;
    logic [1:0]       alu_op;
    logic [OPC_W-1:0] opcode;
    logic             out_valid;
    logic [OP_W-1:0]  alu_operation;
    logic             illegal;
    logic             busy;

    modport master (
        output in_valid, stall, flush, alu_op, opcode,
        input  in_ready, out_valid, alu_operation, illegal, busy
    );

    modport slave (
        input  in_valid, stall, flush, alu_op, opcode,
        output in_ready, out_valid, alu_operation, illegal, busy
    );
endinterface

// File: rtl/alu_ctrl_pipe.sv
// Registered ALU control decoder for the ID/EX boundary.
// Adds illegal-op detection, stall/flush, a valid/ready handshake, and a MUL/DIV busy sequencer.
module alu_ctrl_pipe #(
    parameter int OPC_W      = 11,
    parameter int OP_W       = 4,
    parameter bit EXT_EN     = 1'b1,
    parameter int MUL_CYCLES = 4,
    parameter int DIV_CYCLES = 16
) (
    input  logic           clk,
    input  logic           reset_n,
    alu_ctrl_pipe_if.slave bus
);
    localparam int CMAX  = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
    localparam int CNT_W = (CMAX > 1) ? $clog2(CMAX) : 1;

    localparam logic [10:0] OPC_AND  = 11'b10001010000;
    localparam logic [10:0] OPC_ORR  = 11'b10101010000;
    localparam logic [10:0] OPC_ADD  = 11'b10001011000;
    localparam logic [10:0] OPC_SUB  = 11'b11001011000;
    localparam logic [10:0] OPC_PASB = 11'b11111000010;
    localparam logic [10:0] OPC_NOR  = 11'b11101010000;
    localparam logic [10:0] OPC_EOR  = 11'b11001010000;
    localparam logic [10:0] OPC_LSL  = 11'b11010011011;
    localparam logic [10:0] OPC_LSR  = 11'b11010011010;
    localparam logic [10:0] OPC_MUL  = 11'b10011011000;
    localparam logic [10:0] OPC_DIV  = 11'b10011010110;
    localparam logic [10:0] OPC_LDUR = 11'b11111000010;
    localparam logic [10:0] OPC_STUR = 11'b11111000000;

    typedef enum logic {S_IDLE, S_BUSY} state_t;

    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             out_valid_q;
    logic [OP_W-1:0]  op_q;
    logic             ill_q;

    logic [10:0]      opc;
    logic [OP_W-1:0]  op_d;
    logic             ill_d;
    logic             mul_d;
    logic             div_d;
    logic             accept;

    // Only the top 11 opcode bits carry the function encoding.
    assign opc = bus.opcode[OPC_W-1 -: 11];

    always_comb begin
        op_d  = '0;
        ill_d = 1'b1;
        mul_d = 1'b0;
        div_d = 1'b0;
        case (bus.alu_op)
            2'b10: begin
                case (opc)
                    OPC_AND:  begin op_d = OP_W'(4'd0);  ill_d = 1'b0; end
                    OPC_ORR:  begin op_d = OP_W'(4'd1);  ill_d = 1'b0; end
                    OPC_ADD:  begin op_d = OP_W'(4'd2);  ill_d = 1'b0; end
                    OPC_SUB:  begin op_d = OP_W'(4'd6);  ill_d = 1'b0; end
                    OPC_PASB: begin op_d = OP_W'(4'd7);  ill_d = 1'b0; end
                    OPC_NOR:  begin op_d = OP_W'(4'd12); ill_d = 1'b0; end
                    OPC_EOR:  if (EXT_EN) begin op_d = OP_W'(4'd3); ill_d = 1'b0; end
                    OPC_LSL:  if (EXT_EN) begin op_d = OP_W'(4'd8); ill_d = 1'b0; end
                    OPC_LSR:  if (EXT_EN) begin op_d = OP_W'(4'd9); ill_d = 1'b0; end
                    OPC_MUL:  if (EXT_EN) begin op_d = OP_W'(4'd10); ill_d = 1'b0; mul_d = 1'b1; end
                    OPC_DIV:  if (EXT_EN) begin op_d = OP_W'(4'd11); ill_d = 1'b0; div_d = 1'b1; end
                    default:  ;
                endcase
            end
            2'b00: begin
                if (opc == OPC_LDUR || opc == OPC_STUR) begin
                    op_d  = OP_W'(4'd2);
                    ill_d = 1'b0;
                end
            end
            2'b01: begin
                op_d  = OP_W'(4'd7);
                ill_d = 1'b0;
            end
            default: ;
        endcase
    end

    assign bus.in_ready = !bus.stall && (state_q == S_IDLE);
    assign accept       = bus.in_valid && bus.in_ready && !bus.flush;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            op_q        <= '0;
            ill_q       <= 1'b0;
        end else if (bus.flush) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            ill_q       <= 1'b0;
        end else begin
            // The functional unit cannot be stalled, so the sequencer runs regardless of stall.
            if (state_q == S_BUSY) begin
                if (cnt_q == '0) state_q <= S_IDLE;
                else             cnt_q   <= cnt_q - CNT_W'(1);
            end
            // An accept is impossible while busy, so the sequencer writes never collide.
            if (accept) begin
                out_valid_q <= 1'b1;
                op_q        <= op_d;
                ill_q       <= ill_d;
                if (mul_d) begin
                    state_q <= S_BUSY;
                    cnt_q   <= CNT_W'(MUL_CYCLES - 1);
                end else if (div_d) begin
                    state_q <= S_BUSY;
                    cnt_q   <= CNT_W'(DIV_CYCLES - 1);
                end
            end else if (!bus.stall) begin
                if (state_q == S_IDLE || cnt_q == '0) out_valid_q <= 1'b0;
            end
        end
    end

    assign bus.out_valid     = out_valid_q;
    assign bus.alu_operation = op_q;
    assign bus.illegal       = ill_q;
    assign bus.busy          = (state_q == S_BUSY);
endmodule

// File: tb/tb_alu_ctrl_pipe.sv
// Directed bench for alu_ctrl_pipe: decode table vectors plus handshake, sequencer, stall, flush and reset sequences.
// Two instances run side by side, one with the extended ops enabled and one without.
module tb_alu_ctrl_pipe;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    alu_ctrl_pipe_if #(.OPC_W(11), .OP_W(4)) if1 ();
    alu_ctrl_pipe_if #(.OPC_W(11), .OP_W(4)) if0 ();

    alu_ctrl_pipe #(.OPC_W(11), .OP_W(4), .EXT_EN(1'b1), .MUL_CYCLES(4), .DIV_CYCLES(16))
        u_ext1 (.clk(clk), .reset_n(reset_n), .bus(if1));
    alu_ctrl_pipe #(.OPC_W(11), .OP_W(4), .EXT_EN(1'b0), .MUL_CYCLES(4), .DIV_CYCLES(16))
        u_ext0 (.clk(clk), .reset_n(reset_n), .bus(if0));

    typedef struct {
        logic [1:0]  aop;
        logic [10:0] opc;
        logic [3:0]  e1_op;
        logic        e1_ill;
        logic [3:0]  e0_op;
        logic        e0_ill;
    } vec_t;

    vec_t tbl [16];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic v, input logic [1:0] aop, input logic [10:0] opc);
        if1.in_valid = v; if1.alu_op = aop; if1.opcode = opc;
        if0.in_valid = v; if0.alu_op = aop; if0.opcode = opc;
    endtask

    task automatic ctl(input logic st, input logic fl);
        if1.stall = st; if1.flush = fl;
        if0.stall = st; if0.flush = fl;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    localparam logic [10:0] ADD = 11'b10001011000;
    localparam logic [10:0] SUB = 11'b11001011000;
    localparam logic [10:0] ORR = 11'b10101010000;
    localparam logic [10:0] LDR = 11'b11111000010;
    localparam logic [10:0] MUL = 11'b10011011000;
    localparam logic [10:0] DIV = 11'b10011010110;

    initial begin
        tbl[0]  = '{2'b10, 11'b10001010000, 4'd0,  1'b0, 4'd0,  1'b0};
        tbl[1]  = '{2'b10, 11'b10101010000, 4'd1,  1'b0, 4'd1,  1'b0};
        tbl[2]  = '{2'b10, 11'b10001011000, 4'd2,  1'b0, 4'd2,  1'b0};
        tbl[3]  = '{2'b10, 11'b11001011000, 4'd6,  1'b0, 4'd6,  1'b0};
        tbl[4]  = '{2'b10, 11'b11111000010, 4'd7,  1'b0, 4'd7,  1'b0};
        tbl[5]  = '{2'b10, 11'b11101010000, 4'd12, 1'b0, 4'd12, 1'b0};
        tbl[6]  = '{2'b10, 11'b11001010000, 4'd3,  1'b0, 4'd0,  1'b1};
        tbl[7]  = '{2'b10, 11'b11010011011, 4'd8,  1'b0, 4'd0,  1'b1};
        tbl[8]  = '{2'b10, 11'b11010011010, 4'd9,  1'b0, 4'd0,  1'b1};
        tbl[9]  = '{2'b00, 11'b11111000010, 4'd2,  1'b0, 4'd2,  1'b0};
        tbl[10] = '{2'b00, 11'b11111000000, 4'd2,  1'b0, 4'd2,  1'b0};
        tbl[11] = '{2'b00, 11'b10001011000, 4'd0,  1'b1, 4'd0,  1'b1};
        tbl[12] = '{2'b01, 11'b10110100101, 4'd7,  1'b0, 4'd7,  1'b0};
        tbl[13] = '{2'b01, 11'b00000000000, 4'd7,  1'b0, 4'd7,  1'b0};
        tbl[14] = '{2'b10, 11'b00000000000, 4'd0,  1'b1, 4'd0,  1'b1};
        tbl[15] = '{2'b11, 11'b10001011000, 4'd0,  1'b1, 4'd0,  1'b1};

        drive(1'b0, 2'b00, 11'd0);
        ctl(1'b0, 1'b0);
        #3;
        chk("rst_out_valid", 32'(if1.out_valid), 32'd0);
        chk("rst_op", 32'(if1.alu_operation), 32'd0);
        chk("rst_illegal", 32'(if1.illegal), 32'd0);
        chk("rst_busy", 32'(if1.busy), 32'd0);
        chk("rst_in_ready", 32'(if1.in_ready), 32'd1);
        @(negedge clk);
        reset_n = 1'b1;
        step();
        chk("post_rst_out_valid", 32'(if1.out_valid), 32'd0);

        // Decode table, applied back-to-back.
        for (int i = 0; i < 16; i++) begin
            drive(1'b1, tbl[i].aop, tbl[i].opc);
            chk($sformatf("tbl%0d_in_ready", i), 32'(if1.in_ready), 32'd1);
            step();
            chk($sformatf("tbl%0d_e1_valid", i), 32'(if1.out_valid), 32'd1);
            chk($sformatf("tbl%0d_e1_op", i), 32'(if1.alu_operation), 32'(tbl[i].e1_op));
            chk($sformatf("tbl%0d_e1_ill", i), 32'(if1.illegal), 32'(tbl[i].e1_ill));
            chk($sformatf("tbl%0d_e0_op", i), 32'(if0.alu_operation), 32'(tbl[i].e0_op));
            chk($sformatf("tbl%0d_e0_ill", i), 32'(if0.illegal), 32'(tbl[i].e0_ill));
            chk($sformatf("tbl%0d_e1_busy", i), 32'(if1.busy), 32'd0);
        end

        // Bubble: out_valid drops, op/illegal hold.
        drive(1'b0, 2'b10, ADD);
        step();
        chk("bubble_valid", 32'(if1.out_valid), 32'd0);
        chk("bubble_op_hold", 32'(if1.alu_operation), 32'd0);
        chk("bubble_ill_hold", 32'(if1.illegal), 32'd1);

        // Back-to-back ADD, SUB, ORR, LDUR.
        drive(1'b1, 2'b10, ADD); step();
        chk("b2b_add", 32'(if1.alu_operation), 32'd2);
        chk("b2b_rdy0", 32'(if1.in_ready), 32'd1);
        drive(1'b1, 2'b10, SUB); step();
        chk("b2b_sub", 32'(if1.alu_operation), 32'd6);
        chk("b2b_v1", 32'(if1.out_valid), 32'd1);
        drive(1'b1, 2'b10, ORR); step();
        chk("b2b_orr", 32'(if1.alu_operation), 32'd1);
        chk("b2b_v2", 32'(if1.out_valid), 32'd1);
        drive(1'b1, 2'b00, LDR); step();
        chk("b2b_ldur", 32'(if1.alu_operation), 32'd2);
        chk("b2b_v3", 32'(if1.out_valid), 32'd1);
        chk("b2b_rdy3", 32'(if1.in_ready), 32'd1);

        // MUL: busy exactly 4 cycles, waiting SUB taken after busy falls.
        drive(1'b1, 2'b10, MUL); step();
        chk("e0_mul_ill", 32'(if0.illegal), 32'd1);
        chk("e0_mul_busy", 32'(if0.busy), 32'd0);
        chk("e0_mul_valid", 32'(if0.out_valid), 32'd1);
        chk("e0_mul_op", 32'(if0.alu_operation), 32'd0);
        drive(1'b1, 2'b10, SUB);
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("mul_busy%0d", k), 32'(if1.busy), 32'd1);
            chk($sformatf("mul_rdy%0d", k), 32'(if1.in_ready), 32'd0);
            chk($sformatf("mul_valid%0d", k), 32'(if1.out_valid), 32'd1);
            chk($sformatf("mul_op%0d", k), 32'(if1.alu_operation), 32'd10);
            step();
        end
        chk("mul_busy_end", 32'(if1.busy), 32'd0);
        chk("mul_rdy_end", 32'(if1.in_ready), 32'd1);
        chk("mul_valid_end", 32'(if1.out_valid), 32'd0);
        step();
        chk("mul_sub_op", 32'(if1.alu_operation), 32'd6);
        chk("mul_sub_valid", 32'(if1.out_valid), 32'd1);
        chk("mul_sub_ill", 32'(if1.illegal), 32'd0);

        // Stall holds outputs for 3 cycles.
        drive(1'b1, 2'b10, ADD);
        ctl(1'b1, 1'b0);
        #1;
        chk("stall_rdy", 32'(if1.in_ready), 32'd0);
        for (int k = 0; k < 3; k++) begin
            step();
            chk($sformatf("stall_op%0d", k), 32'(if1.alu_operation), 32'd6);
            chk($sformatf("stall_valid%0d", k), 32'(if1.out_valid), 32'd1);
        end
        // Flush with stall and in_valid: request dropped.
        ctl(1'b1, 1'b1);
        step();
        chk("flush_st_valid", 32'(if1.out_valid), 32'd0);
        chk("flush_st_op_hold", 32'(if1.alu_operation), 32'd6);
        // Flush alone: in_ready stays high, request still dropped.
        ctl(1'b0, 1'b1);
        #1;
        chk("flush_rdy", 32'(if1.in_ready), 32'd1);
        step();
        chk("flush_drop_valid", 32'(if1.out_valid), 32'd0);
        chk("flush_drop_op", 32'(if1.alu_operation), 32'd6);
        ctl(1'b0, 1'b0);
        drive(1'b0, 2'b10, ADD);
        step();
        chk("after_flush_valid", 32'(if1.out_valid), 32'd0);

        // DIV flushed at busy cycle 5.
        drive(1'b1, 2'b10, DIV); step();
        chk("div_busy1", 32'(if1.busy), 32'd1);
        chk("div_op", 32'(if1.alu_operation), 32'd11);
        drive(1'b0, 2'b10, ADD);
        repeat (4) step();
        chk("div_busy5", 32'(if1.busy), 32'd1);
        chk("div_valid5", 32'(if1.out_valid), 32'd1);
        ctl(1'b0, 1'b1);
        step();
        chk("div_flush_busy", 32'(if1.busy), 32'd0);
        chk("div_flush_valid", 32'(if1.out_valid), 32'd0);
        chk("div_flush_rdy", 32'(if1.in_ready), 32'd1);
        chk("div_flush_op_hold", 32'(if1.alu_operation), 32'd11);
        ctl(1'b0, 1'b0);
        step();
        chk("div_stays_idle", 32'(if1.busy), 32'd0);

        // Reset mid-MUL, at busy cycle 2.
        drive(1'b1, 2'b10, MUL); step();
        drive(1'b0, 2'b10, ADD); step();
        chk("mr_busy_pre", 32'(if1.busy), 32'd1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("mr_valid", 32'(if1.out_valid), 32'd0);
        chk("mr_op", 32'(if1.alu_operation), 32'd0);
        chk("mr_ill", 32'(if1.illegal), 32'd0);
        chk("mr_busy", 32'(if1.busy), 32'd0);
        chk("mr_e0_ill", 32'(if0.illegal), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        drive(1'b1, 2'b10, ADD);
        step();
        chk("mr_add_valid", 32'(if1.out_valid), 32'd1);
        chk("mr_add_op", 32'(if1.alu_operation), 32'd2);
        chk("mr_add_busy", 32'(if1.busy), 32'd0);
        drive(1'b0, 2'b10, ADD);
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/alu_ctrl_pipe.md
Name: alu_ctrl_pipe

Overview:
- Parametrised, registered successor to the combinational ALU control decoder.
- Decodes {ALUOp, Opcode} into an ALU operation code and registers it at the ID/EX boundary.
- Adds an explicit illegal-op flag, pipeline stall/flush, a valid/ready handshake, and a multi-cycle busy sequencer for MUL/DIV.
- Sits between the main control unit and the EX-stage ALU.

Parameters:
- OPC_W, 11, opcode field width; only the upper 11 bits (MSBs) are decoded.
- OP_W, 4, ALU operation code width; must be ≥4.
- EXT_EN, 1, 1 enables EOR/LSL/LSR/MUL/DIV decode; 0 makes them illegal.
- MUL_CYCLES, 4, busy cycles for MUL; range 1..255.
- DIV_CYCLES, 16, busy cycles for DIV; range 1..255.

Ports:
- clk  in  1  rising-edge clock
- reset_n  in  1  asynchronous, active-low reset
- in_valid  in  1  decode request present
- in_ready  out  1  combinational; = !stall && !busy
- stall  in  1  hold the registered outputs
- flush  in  1  squash the registered op and abort the sequencer
- alu_op  in  2  ALUOp from main control
- opcode  in  OPC_W  instruction opcode field
- out_valid  out  1  registered op is valid for EX
- alu_operation  out  OP_W  registered ALU operation code
- illegal  out  1  registered op was undecodable
- busy  out  1  multi-cycle op in progress

Behaviour:
- Reset (async, reset_n=0): out_valid=0, alu_operation=0, illegal=0, busy=0, counter=0. Outputs recover on the first clk edge after release.
- Decode table (zero-extended to OP_W):
  - ALUOp=10: AND 10001010000→0; ORR 10101010000→1; ADD 10001011000→2; SUB 11001011000→6; pass-B 11111000010→7; NOR 11101010000→12.
  - ALUOp=10, EXT_EN=1 only: EOR 11001010000→3; LSL 11010011011→8; LSR 11010011010→9; MUL 10011011000→10; DIV 10011010110→11.
  - ALUOp=00: LDUR 11111000010 and STUR 11111000000→2.
  - ALUOp=01: any opcode→7 (CBZ pass-B).
  - Anything else: illegal=1, alu_operation=0. Never X.
- Accept: accept = in_valid && in_ready && !flush, sampled on the rising edge.
- Latency: 1 cycle. On accept, the next edge loads alu_operation/illegal and sets out_valid=1.
- No accept, !stall, !busy: out_valid→0 (bubble); alu_operation/illegal hold their last values.
- Stall: out_valid, alu_operation, illegal hold. The sequencer counter keeps counting because the functional unit is not stallable.
- Multi-cycle sequencer:
  - On accept of a legal MUL (DIV), busy=1 and counter=MUL_CYCLES-1 (DIV_CYCLES-1) at the same edge as out_valid.
  - Each subsequent edge: if counter==0, busy→0; else counter decrements.
  - busy is therefore high for exactly N cycles.
  - While busy, outputs hold and out_valid stays 1.
  - When busy drops, out_valid→0 on that same edge unless a new accept occurs. A new op cannot be accepted until in_ready rises (the cycle after busy falls).
- Flush: highest priority, overrides stall and accept. Next edge: out_valid=0, illegal=0, busy=0, counter=0; alu_operation holds.
- Simultaneous in_valid and flush: the request is dropped; in_ready is unaffected (flush is not in the in_ready equation).
- Illegal accept: out_valid=1, illegal=1, busy not started.
- Counter width: $clog2 of the maximum of MUL_CYCLES and DIV_CYCLES, minimum 1.

Test Plan:
- Reset mid-MUL: at cycle 2 of busy, drive reset_n=0 → all outputs 0 immediately without a clock edge; after release and one accepted ADD, out_valid=1 and alu_operation=2.
- Back-to-back single-cycle ops: accept ADD, SUB, ORR, LDUR in consecutive cycles → alu_operation 2, 6, 1, 2 one cycle after each; out_valid stays high; in_ready=1 throughout.
- MUL with MUL_CYCLES=4: accept MUL → alu_operation=10 and busy=1 for exactly 4 cycles; in_ready=0 for those 4 cycles; a waiting SUB is accepted the cycle after busy falls and appears 1 cycle later as 6.
- Stall/flush: during stall, outputs hold over 3 cycles. Assert flush with stall and in_valid together → out_valid=0 next edge and the request is dropped. Flush at DIV busy cycle 5 → busy=0 next edge.
- Illegal and EXT_EN: with EXT_EN=1, opcode 00000000000 under ALUOp=10 → illegal=1, alu_operation=0, out_valid=1. With EXT_EN=0, MUL → illegal=1, busy stays 0.
- ALUOp=01 with opcode 10110100xxx → alu_operation=7, illegal=0.
